// File: rtl/demux_16_buf.sv
// Registered 1-to-16 demultiplexer with per-lane valid/ack, ready/valid input and occupancy count.
// Optional write counter output WR_CNT enabled by defining DEMUX_16_STATS_EN.
module demux_16_buf #(
    parameter int WIDTH = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [WIDTH-1:0]    IN,
    input  logic [3:0]          SEL,
    input  logic                IN_VALID,
    output logic                IN_READY,
    output logic [16*WIDTH-1:0] OUT,
    output logic [15:0]         OUT_VALID,
    input  logic [15:0]         ACK,
`ifdef DEMUX_16_STATS_EN
    output logic [15:0]         WR_CNT,
`endif
    output logic [4:0]          OCCUPANCY
);

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    lane_state_e      state_q [16];
    lane_state_e      state_d [16];
    logic [WIDTH-1:0] data_q  [16];
    logic [WIDTH-1:0] data_d  [16];
    logic [4:0]       occ_q;
    logic [4:0]       occ_d;
    logic [15:0]      valid_vec;
    logic             accept;
    logic             inc;
    logic [4:0]       dec;

    always_comb begin
        valid_vec = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            valid_vec[k] = (state_q[k] == LANE_FULL);
        end
    end

    // A same-cycle ACK on the target lane frees it for the incoming word.
    assign IN_READY = ~RST & (~valid_vec[SEL] | ACK[SEL]);
    assign accept   = IN_VALID & IN_READY;

    always_comb begin
        for (int unsigned k = 0; k < 16; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (accept && (SEL == 4'(k))) begin
                state_d[k] = LANE_FULL;
                data_d[k]  = IN;
            end else if (ACK[k] && (state_q[k] == LANE_FULL)) begin
                state_d[k] = LANE_EMPTY;
            end
        end
    end

    // An ACK on the lane being written is absorbed by the accept, so it does not count as a release.
    always_comb begin
        inc = accept & ~valid_vec[SEL];
        dec = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (ACK[k] && valid_vec[k] && !(accept && (SEL == 4'(k)))) begin
                dec = dec + 5'd1;
            end
        end
        occ_d = occ_q + {4'b0000, inc} - dec;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned k = 0; k < 16; k++) begin
                state_q[k] <= LANE_EMPTY;
                data_q[k]  <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int unsigned k = 0; k < 16; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            occ_q <= occ_d;
        end
    end

    always_comb begin
        OUT = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            OUT[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign OUT_VALID = valid_vec;
    assign OCCUPANCY = occ_q;

`ifdef DEMUX_16_STATS_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] wr_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (accept && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign WR_CNT = wr_cnt_q;
`endif

endmodule

// File: tb/tb_demux_16_buf.sv
// Self-checking bench for demux_16_buf: a behavioural lane model feeds a scoreboard queue
// of expected post-edge outputs, popped and compared one cycle after each stimulus.
module tb_demux_16_buf;
    localparam int W  = 32;
    localparam int CW = 16 * W;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  IN = '0;
    logic [3:0]    SEL = '0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [CW-1:0] OUT;
    logic [15:0]   OUT_VALID;
    logic [15:0]   ACK = '0;
    logic [4:0]    OCCUPANCY;
`ifdef DEMUX_16_STATS_EN
    logic [15:0]   WR_CNT;
`endif

    always #5 CLK = ~CLK;

    demux_16_buf #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN        (IN),
        .SEL       (SEL),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .ACK       (ACK),
`ifdef DEMUX_16_STATS_EN
        .WR_CNT    (WR_CNT),
`endif
        .OCCUPANCY (OCCUPANCY)
    );

    typedef struct {
        logic [CW-1:0] out;
        logic [15:0]   vld;
        logic [4:0]    occ;
        logic [15:0]   wr;
    } exp_t;

    exp_t        sb[$];
    logic [W-1:0] m_data[16];
    logic [15:0] m_vld = '0;
    logic [15:0] m_wr  = '0;
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: check IN_READY, advance the model, queue the expectation, compare after the edge.
    task automatic step(input logic rst, input logic v, input logic [3:0] s,
                        input logic [W-1:0] d, input logic [15:0] a);
        logic rdy;
        logic acc;
        exp_t e;
        RST = rst; IN_VALID = v; SEL = s; IN = d; ACK = a;
        #1;
        rdy = !rst && (!m_vld[s] || a[s]);
        check_val("in_ready", CW'(IN_READY), CW'(rdy));
        acc = v && rdy;
        if (rst) begin
            for (int k = 0; k < 16; k++) m_data[k] = '0;
            m_vld = '0;
            m_wr  = '0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (acc && (int'(s) == k)) begin
                    m_vld[k]  = 1'b1;
                    m_data[k] = d;
                end else if (a[k]) begin
                    m_vld[k] = 1'b0;
                end
            end
            if (acc && m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
        end
        for (int k = 0; k < 16; k++) e.out[k*W +: W] = m_data[k];
        e.vld = m_vld;
        e.occ = 5'($countones(m_vld));
        e.wr  = m_wr;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", CW'(1), CW'(0));
        end else begin
            e = sb.pop_front();
            check_val("out_valid", CW'(OUT_VALID), CW'(e.vld));
            check_val("occupancy", CW'(OCCUPANCY), CW'(e.occ));
            check_val("out_data", OUT, e.out);
`ifdef DEMUX_16_STATS_EN
            check_val("wr_cnt", CW'(WR_CNT), CW'(e.wr));
`endif
        end
    endtask

    task automatic idle(input logic [15:0] a);
        step(1'b0, 1'b0, 4'd0, '0, a);
    endtask

    task automatic wr(input logic [3:0] s, input logic [W-1:0] d, input logic [15:0] a);
        step(1'b0, 1'b1, s, d, a);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) m_data[k] = '0;
        #1;
        // Reset then idle
        step(1'b1, 1'b0, 4'd0, '0, '0);
        step(1'b1, 1'b0, 4'd0, '0, '0);
        idle('0);

        // Single write and consume, lane data retained after ACK
        wr(4'd5, 32'hDEADBEEF, '0);
        check_val("lane5_data", CW'(OUT[5*W +: W]), CW'(32'hDEADBEEF));
        idle(16'h0020);
        check_val("lane5_kept", CW'(OUT[5*W +: W]), CW'(32'hDEADBEEF));
        idle('0);

        // Backpressure on full lane 3, then ACK frees it in the same cycle
        wr(4'd3, 32'hAAAA5555, '0);
        for (int i = 0; i < 3; i++) wr(4'd3, 32'h1, '0);
        check_val("lane3_held", CW'(OUT[3*W +: W]), CW'(32'hAAAA5555));
        wr(4'd3, 32'h1, 16'h0008);
        check_val("lane3_swap", CW'(OUT[3*W +: W]), CW'(32'h1));
        idle(16'hFFFF);

        // Fill every lane, confirm no lane accepts, then drain all at once
        for (int s = 0; s < 16; s++) wr(4'(s), 32'(s) + 32'h100, '0);
        for (int s = 0; s < 16; s++) wr(4'(s), 32'hBAD0_0000, '0);
        idle(16'hFFFF);

        // Accept into empty lane 9 while releasing lanes 2 and 7
        wr(4'd2, 32'h22, '0);
        wr(4'd7, 32'h77, '0);
        wr(4'd9, 32'h99, 16'h0084);
        idle(16'h0200);

        // Reset mid-stream with a pending write
        wr(4'd1, 32'h11, '0);
        wr(4'd4, 32'h44, '0);
        step(1'b1, 1'b1, 4'd6, 32'h66, 16'h0002);
        idle('0);

        // Random traffic including ACKs on empty lanes and occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom),
                 $urandom, 16'($urandom) & 16'($urandom));
        end

`ifdef DEMUX_16_STATS_EN
        step(1'b1, 1'b0, 4'd0, '0, '0);
        for (int i = 0; i < 70000; i++) wr(4'(i), 32'(i), 16'hFFFF);
        check_val("wr_cnt_sat", CW'(WR_CNT), CW'(16'hFFFF));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/demux_16_buf.md
Name: demux_16_buf

Overview:
- Registered 1-to-16 demultiplexer that steers one WIDTH-bit word into one of 16 holding lanes.
- Each lane has its own valid flag and a per-lane consumer acknowledge.
- Serves as the distribution counterpart to the 16:1 select path: it fans processor-side writes (write-back results, control words) out to 16 downstream consumers.
- Includes ready/valid backpressure and a registered occupancy count.

Parameters:
- WIDTH, 32, data width of the input word and of each output lane.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- IN  input  WIDTH  write data.
- SEL  input  4  destination lane index, 0..15.
- IN_VALID  input  1  source offers IN/SEL this cycle.
- IN_READY  output  1  combinational; the block can accept this cycle.
- OUT  output  16*WIDTH  lane k data at OUT[k*WIDTH +: WIDTH].
- OUT_VALID  output  16  bit k high while lane k holds unconsumed data.
- ACK  input  16  bit k: consumer k takes lane k this cycle.
- OCCUPANCY  output  5  number of set OUT_VALID bits, 0..16.

Behaviour:
- IN_READY = ~RST & (~OUT_VALID[SEL] | ACK[SEL]). Same-cycle consume of the target lane frees it for the incoming word.
- accept = IN_VALID & IN_READY.
- On accept at the CLK edge: lane SEL data <= IN and OUT_VALID[SEL] <= 1.
  - Latency: 1 cycle, IN to OUT/OUT_VALID.
- ACK[k] with OUT_VALID[k]=1 and no accept to k: OUT_VALID[k] <= 0 at the edge.
  - Lane data is retained, not cleared.
- ACK[k] and accept to k in the same cycle: accept wins. OUT_VALID[k] stays 1 and the lane data is replaced by IN.
- ACK[k] with OUT_VALID[k]=0: ignored, no state change.
- Multiple ACK bits in one cycle: all honoured independently.
- IN_VALID=1 with IN_READY=0 (target lane full, no ACK): no state change. The source must hold IN/SEL stable until accepted; this is not checked.
- IN_VALID=0: SEL and IN are don't-care. IN_READY may toggle with SEL and is meaningful only when IN_VALID=1.
- Non-selected lanes never change except through their own ACK.
- OCCUPANCY (registered) next value = OCCUPANCY + inc - dec, where:
  - inc = accept & ~OUT_VALID[SEL];
  - dec = popcount of (ACK & OUT_VALID) over lanes, excluding lane SEL when accept is high.
  - The result is always in 0..16. OCCUPANCY=16 means all lanes full; IN_READY is then 0 unless ACK[SEL] is high.
- Reset (RST=1 at the edge): all OUT lanes <= 0, OUT_VALID <= 16'h0000, OCCUPANCY <= 0.
  - IN_READY is 0 while RST is high.
  - Reset overrides any same-cycle accept or ACK.
  - Reset mid-stream discards all held lanes; nothing is replayed.
- No state machine beyond the per-lane valid flags. Each lane is a 2-state EMPTY/FULL element with the transitions above.

Optional Feature:
- Macro: DEMUX_16_STATS_EN.
- Defined: adds output WR_CNT, 16 bits, registered.
  - Increments by 1 on each accept and saturates at 16'hFFFF; no wrap.
  - Reset value 0.
- Not defined: port WR_CNT and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, IN_VALID=0 -> OUT=0, OUT_VALID=16'h0000, OCCUPANCY=0, IN_READY=0 during RST and 1 after RST drops.
- Single write and consume: IN=32'hDEADBEEF, SEL=5, IN_VALID=1 for one cycle, then ACK=16'h0020 one cycle later -> next cycle OUT lane 5=32'hDEADBEEF, OUT_VALID=16'h0020, OCCUPANCY=1. After the ACK edge: OUT_VALID=0, OCCUPANCY=0, lane 5 still 32'hDEADBEEF.
- Backpressure: lane 3 full, IN_VALID=1, SEL=3, IN=32'h1, ACK=0 for 3 cycles -> IN_READY=0, lane 3 keeps its old data. Then assert ACK[3] -> IN_READY=1 that cycle; next cycle lane 3=32'h1, OUT_VALID[3]=1, OCCUPANCY unchanged.
- Fill all lanes: write SEL=0..15 on consecutive cycles with IN=SEL+32'h100 -> OCCUPANCY steps 1..16, OUT_VALID=16'hFFFF, IN_READY=0 for any SEL. Then ACK=16'hFFFF with IN_VALID=0 for one cycle -> OCCUPANCY=0.
- Simultaneous accept plus other ACKs: lanes 2 and 7 full, accept to empty lane 9 with ACK=16'h0084 -> next cycle OUT_VALID=16'h0200, OCCUPANCY goes 2 -> 1.
- Reset mid-stream: lanes 1 and 4 full, RST=1 with IN_VALID=1, SEL=6 -> after the edge all lanes=0, OUT_VALID=0, OCCUPANCY=0, WR_CNT=0 if DEMUX_16_STATS_EN. With the macro defined, 70000 accepts leave WR_CNT=16'hFFFF.
